// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch control ahead of the instruction memory.
// Drives the memory word address, tracks the one-cycle registered read latency,
// re-presents the current word on stall and squashes the wrong-path word on redirect.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             hold fetch and re-present the current instruction
//   branch_en         redirect request, sampled at the clock edge
//   branch_target     absolute word address of the redirect
//   pc_addr           address to memory ADDR_Prog (combinational from stall)
//   pc_fetched        PC of the word currently on memory data_out
//   if_valid          data_out holds a real, non-squashed instruction
//   fetch_count       instructions accepted (only with FETCH_COUNT_EN)
//
// Optional feature: define FETCH_COUNT_EN to add the fetch_count port and counter.
module fetch_pc_unit #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   PC_BASE  = 'h1030
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc_addr,
  output logic [PC_WIDTH-1:0] pc_fetched,
  output logic                if_valid
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]         fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc_reg;
  logic [PC_WIDTH-1:0] r_pc_fetched;
  logic                r_if_valid;
  logic [PC_WIDTH-1:0] w_pc_addr;
  logic                w_no_word;

  // Stall re-fetches the word already on data_out so it is presented again unchanged.
  assign w_pc_addr  = stall ? r_pc_fetched : r_pc_reg;
  assign pc_addr    = w_pc_addr;
  assign pc_fetched = r_pc_fetched;
  assign if_valid   = r_if_valid;

  // START and FLUSH never have a real word on data_out.
  assign w_no_word = (r_state == S_START) || (r_state == S_FLUSH);

  // Fetch FSM; priority is reset, redirect, stall, sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_START;
      r_pc_reg     <= PC_BASE;
      r_pc_fetched <= PC_BASE;
      r_if_valid   <= 1'b0;
    end else if (branch_en) begin
      r_state    <= S_FLUSH;
      r_pc_reg   <= branch_target;
      r_if_valid <= 1'b0;
    end else if (stall) begin
      r_state    <= S_STALL;
      r_if_valid <= w_no_word ? 1'b0 : r_if_valid;
    end else begin
      r_state      <= S_RUN;
      r_pc_reg     <= r_pc_reg + PC_WIDTH'(1);
      r_pc_fetched <= w_pc_addr;
      r_if_valid   <= 1'b1;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] r_fetch_count;

  // A word is accepted when it is valid and the pipe advances past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'd0;
    end else if (r_if_valid && !stall && !branch_en) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] BASE = 32'h1030;

  typedef struct {
    logic [31:0] fetched;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] pc_addr;
  logic [31:0] pc_fetched;
  logic        if_valid;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_fetched;
  logic        m_valid;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  fetch_pc_unit #(.PC_WIDTH(32), .PC_BASE(32'h1030)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .pc_addr       (pc_addr),
    .pc_fetched    (pc_fetched),
    .if_valid      (if_valid)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational address, predict and check registered state.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; stall = s; branch_en = b; branch_target = t;
    #1;
    chk("pc_addr", pc_addr, s ? m_fetched : m_pc);
    if (r) begin
      m_pc = BASE; m_fetched = BASE; m_valid = 1'b0; m_cnt = 32'd0;
    end else if (b) begin
      m_pc = t; m_valid = 1'b0;
    end else if (!s) begin
      if (m_valid) m_cnt = m_cnt + 32'd1;
      m_fetched = m_pc;
      m_pc      = m_pc + 32'd1;
      m_valid   = 1'b1;
    end
    e.fetched = m_fetched; e.valid = m_valid; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      chk("pc_fetched", pc_fetched, got.fetched);
      chk("if_valid", 32'(if_valid), 32'(got.valid));
`ifdef FETCH_COUNT_EN
      chk("fetch_count", fetch_count, got.cnt);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 32'd0;
    m_pc = 32'hDEAD; m_fetched = 32'hDEAD; m_valid = 1'b0; m_cnt = 32'd0;

    // Reset (pc_addr check on first cycle is after model reset)
    @(posedge clk); #1;
    m_pc = BASE; m_fetched = BASE;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("rst_pc_fetched", pc_fetched, 32'h1030);
    chk("rst_if_valid", 32'(if_valid), 32'd0);

    // Free-run
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Stall three cycles then release
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Redirect to 0x1040
    cycle(1'b0, 1'b0, 1'b1, 32'h1040);
    chk("flush_squash", 32'(if_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("redirect_fetched", pc_fetched, 32'h1040);
    chk("redirect_valid", 32'(if_valid), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Branch and stall together: redirect wins
    cycle(1'b0, 1'b1, 1'b1, 32'h1050);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("br_stall_fetched", pc_fetched, 32'h1050);
    chk("br_stall_valid", 32'(if_valid), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Stall right after a flush keeps if_valid low
    cycle(1'b0, 1'b0, 1'b1, 32'h1060);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Reset in the middle of a stall
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_fetched", pc_fetched, 32'h1030);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Reset during a flush
    cycle(1'b0, 1'b0, 1'b1, 32'h4000);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Back-to-back redirects, last target wins
    cycle(1'b0, 1'b0, 1'b1, 32'h2000);
    cycle(1'b0, 1'b0, 1'b1, 32'h3000);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("b2b_fetched", pc_fetched, 32'h3000);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Address wrap
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_addr0", pc_addr, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr1", pc_addr, 32'h0000_0000);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr2", pc_addr, 32'h0000_0001);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
